// File: rtl/chacha_pkg.sv
// Shared widths, FSM encoding and keystream word extraction for the ChaCha keystream XOR block.
// Used by chacha_ks_buf and chacha_keystream_xor.
package chacha_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Word 0 is the most significant word of the block.
    function automatic logic [WORD_W-1:0] block_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [IDX_W-1:0]   idx
    );
        return blk[BLOCK_W - 1 - WORD_W * int'(idx) -: WORD_W];
    endfunction

endpackage

// File: rtl/chacha_ks_buf.sv
// Captured keystream block and the index-selected 32-bit keystream word.
module chacha_ks_buf
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] ks_block,
    input  logic [IDX_W-1:0]   idx,
    output logic [WORD_W-1:0]  word
);

    logic [BLOCK_W-1:0] block_q;

    always_ff @(posedge clk) begin
        // NOTE: the block is reset on purpose so no keystream outlives rst.
        if (rst) begin
            block_q <= '0;
        end else if (load) begin
            block_q <= ks_block;
        end
    end

    assign word = block_word(block_q, idx);

endmodule

// File: rtl/chacha_keystream_xor.sv
// XORs a 32-bit data stream with ChaCha keystream words, requesting a new block every 16 words.
// Optional feature: define CHACHA_XOR_WORDCNT_EN to add the word_count output.
module chacha_keystream_xor
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] ks_block,
    input  logic               ks_valid,
    input  logic               core_ready,
    output logic               core_next,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
`ifdef CHACHA_XOR_WORDCNT_EN
    ,
    output logic [31:0]        word_count
`endif
);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               req_pending;
    logic               draining;
    logic [WORD_W-1:0]  ks_word;
    logic               capture;
    logic               accept;
    logic               out_fire;

    assign capture  = (state == ST_WAIT_HI) && ks_valid;
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = out_fire && out_last;

    chacha_ks_buf u_ks_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .ks_block (ks_block),
        .idx      (idx),
        .word     (ks_word)
    );

    // WAIT_LO doubles as the non-accepting hold state: either a block request is
    // outstanding (req_pending / waiting for ks_valid to drop) or the final word drains.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every branch reading pre-edge state.
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            req_pending <= 1'b0;
            draining    <= 1'b0;
            core_next   <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            core_next <= 1'b0;

            if (accept) begin
                out_data  <= in_data ^ ks_word;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        req_pending <= 1'b0;
                        draining    <= 1'b0;
                        state       <= ST_WAIT_HI;
                    end
                end

                ST_WAIT_HI: begin
                    if (ks_valid) begin
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (in_last) begin
                            draining <= 1'b1;
                            state    <= ST_WAIT_LO;
                        end else if (idx == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                            req_pending <= 1'b1;
                            state       <= ST_WAIT_LO;
                        end
                    end
                end

                ST_WAIT_LO: begin
                    if (draining) begin
                        if (out_fire && out_last) begin
                            draining <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (req_pending) begin
                        if (core_ready) begin
                            core_next   <= 1'b1;
                            req_pending <= 1'b0;
                        end
                    end else if (!core_next && !ks_valid) begin
                        // The old block has been withdrawn; the next high is fresh.
                        state <= ST_WAIT_HI;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHACHA_XOR_WORDCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if ((state == ST_IDLE) && start) begin
            word_count <= '0;
        end else if (out_fire) begin
            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Self-checking bench for chacha_keystream_xor: a keystream-source stand-in, a word-level
// expected-output model, a per-cycle compare process and directed message scenarios.
module tb_chacha_keystream_xor;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] ks_block;
    logic         ks_valid;
    logic         core_ready;
    logic         core_next;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         done;
`ifdef CHACHA_XOR_WORDCNT_EN
    logic [31:0]  word_count;
`endif

    chacha_keystream_xor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ks_block   (ks_block),
        .ks_valid   (ks_valid),
        .core_ready (core_ready),
        .core_next  (core_next),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef CHACHA_XOR_WORDCNT_EN
        ,
        .word_count (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Keystream block with counter c: word i = {C, c, 17*i, BEEF^c}.
    function automatic logic [31:0] gen_word(input int c, input int i);
        logic [7:0] mid;
        mid = 8'(i) * 8'd17;
        return {4'hC, 4'(c), mid, 16'hBEEF ^ 16'(c)};
    endfunction

    function automatic logic [511:0] gen_block(input int c);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = gen_word(c, i);
        return b;
    endfunction

    // Expected stream (written by the stimulus) and observed log (written by the compare process).
    logic [31:0] exp_d [0:1023];
    logic        exp_l [0:1023];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [31:0] obs_d [0:1023];
    logic        obs_l [0:1023];
    int          obs_n = 0;
    int          done_cnt = 0;

    // Keystream source: holds ks_valid through the core_next cycle, then low for 3 cycles.
    int init_req = 0;
    int init_seen = 0;
    int stub_ctr = 0;
    int stub_wait = 0;
    bit drop_next = 1'b0;
    int ncn = 0;

    initial begin
        ks_valid = 1'b0;
        ks_block = '0;
        forever begin
            @(posedge clk);
            #2;
            if (init_req != init_seen) begin
                init_seen = init_req;
                stub_ctr  = 0;
                stub_wait = 0;
                drop_next = 1'b0;
                ks_block  = gen_block(0);
                ks_valid  = 1'b1;
            end else if (core_next) begin
                ncn++;
                drop_next = 1'b1;
            end else if (drop_next) begin
                drop_next = 1'b0;
                stub_ctr++;
                ks_valid  = 1'b0;
                stub_wait = 3;
            end else if (stub_wait > 0) begin
                stub_wait--;
                if (stub_wait == 0) begin
                    ks_block = gen_block(stub_ctr);
                    ks_valid = 1'b1;
                end
            end
        end
    end

    // Sink/core readiness: mode 0 = always ready, mode 1 = toggle every cycle.
    int mode = 0;
    initial begin
        out_ready  = 1'b1;
        core_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) begin
                out_ready  = !out_ready;
                core_ready = !out_ready;
            end else begin
                out_ready  = 1'b1;
                core_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the expected stream.
    initial begin
        bit          hold_prev = 1'b0;
        bit          cn_prev   = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rd    = exp_wr;
                hold_prev = 1'b0;
                cn_prev   = 1'b0;
            end else begin
                if (core_next && cn_prev) check("core_next_width", 32'd2, 32'd1);
                cn_prev = core_next;
                if (hold_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, prev_data);
                    check("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && !out_ready) check("in_ready_backpressure", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_rd < exp_wr) begin
                        check("out_data", out_data, exp_d[exp_rd]);
                        check("out_last", 32'(out_last), 32'(exp_l[exp_rd]));
                        check("done_on_last", 32'(done), 32'(exp_l[exp_rd]));
                        exp_rd++;
                    end else begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end
                    obs_d[obs_n] = out_data;
                    obs_l[obs_n] = out_last;
                    obs_n++;
                end else begin
                    check("done_quiet", 32'(done), 32'd0);
                end
                if (done) done_cnt++;
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1;
        init_req++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // kind: 0 = zeros, 1 = all ones, 2 = random. Only the first n_send of n words are fed.
    task automatic send_msg(input int n, input int kind, input int n_send);
        logic [31:0] w;
        int t;
        for (int k = 0; k < n_send; k++) begin
            case (kind)
                0:       w = 32'h0;
                1:       w = 32'hFFFF_FFFF;
                default: w = $urandom;
            endcase
            exp_d[exp_wr] = w ^ gen_word(k / 16, k % 16);
            exp_l[exp_wr] = (k == n - 1);
            exp_wr++;
            in_data  = w;
            in_valid = 1'b1;
            in_last  = (k == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 500);
            if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_rd == exp_wr && !busy && !out_valid) && t < 2000);
        check("drain_timeout", 32'(exp_rd == exp_wr && !busy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_next"}, 32'(core_next), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_data"},  out_data,       32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
`ifdef CHACHA_XOR_WORDCNT_EN
        check({tag, "_word_count"}, word_count, 32'd0);
`endif
    endtask

    initial begin
        int base;
        int cn0;
        int d0;
        int t;
        rst = 1'b1;
        start = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 16 zero words: output is keystream block 0 verbatim, no new block needed.
        base = obs_n; cn0 = ncn; d0 = done_cnt;
        do_start();
        send_msg(16, 0, 16);
        wait_idle();
        check("A_core_next_count", 32'(ncn - cn0), 32'd0);
        check("A_done_count", 32'(done_cnt - d0), 32'd1);
        check("A_word0", obs_d[base], 32'hC000_BEEF);
        check("A_word15", obs_d[base + 15], 32'hC0FF_BEEF);
        check("A_last15", 32'(obs_l[base + 15]), 32'd1);

        // 40 words of ones: blocks 0, 1, 2 with two requests.
        base = obs_n; cn0 = ncn; d0 = done_cnt;
        do_start();
        send_msg(40, 1, 40);
        wait_idle();
        check("B_core_next_count", 32'(ncn - cn0), 32'd2);
        check("B_word_total", 32'(obs_n - base), 32'd40);
        check("B_word0", obs_d[base], 32'h3FFF_4110);
        check("B_word16", obs_d[base + 16], 32'h3EFF_4111);
        check("B_word32", obs_d[base + 32], 32'h3DFF_4112);
        check("B_last38", 32'(obs_l[base + 38]), 32'd0);
        check("B_last39", 32'(obs_l[base + 39]), 32'd1);
        check("B_done_count", 32'(done_cnt - d0), 32'd1);

        // 20 random words with out_ready and core_ready toggling.
        base = obs_n; cn0 = ncn; d0 = done_cnt;
        mode = 1;
        do_start();
        send_msg(20, 2, 20);
        wait_idle();
        mode = 0;
        check("C_word_total", 32'(obs_n - base), 32'd20);
        check("C_core_next_count", 32'(ncn - cn0), 32'd1);
        check("C_done_count", 32'(done_cnt - d0), 32'd1);
`ifdef CHACHA_XOR_WORDCNT_EN
        check("C_word_count", word_count, 32'd20);
`endif

        // 17 zero words: ks_valid stays high through core_next; word 16 must use block 1.
        base = obs_n; cn0 = ncn;
        do_start();
`ifdef CHACHA_XOR_WORDCNT_EN
        @(negedge clk);
        check("D_word_count_cleared", word_count, 32'd0);
`endif
        send_msg(17, 0, 17);
        wait_idle();
        check("D_word16", obs_d[base + 16], 32'hC100_BEEE);
        check("D_core_next_count", 32'(ncn - cn0), 32'd1);

        // Reset after 7 words of a 16-word message.
        base = obs_n;
        do_start();
        send_msg(16, 2, 7);
        t = 0;
        while (obs_n < base + 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("E_seven_out", 32'(obs_n - base), 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("E_midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cn0 = ncn;
        repeat (30) @(posedge clk);
        check("E_no_core_next", 32'(ncn - cn0), 32'd0);
        check("E_idle", 32'(busy), 32'd0);

        // Fresh message after reset restarts at keystream word 0.
        base = obs_n; d0 = done_cnt;
        do_start();
        send_msg(16, 0, 16);
        wait_idle();
        check("F_word0", obs_d[base], 32'hC000_BEEF);
        check("F_word1", obs_d[base + 1], 32'hC011_BEEF);
        check("F_done_count", 32'(done_cnt - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
